hazard_stall_controller: RTL
============================

# hazard_stall_controller

Pipeline hazard controller for the 5-stage MIPS core. Decides each cycle whether IF/ID hold, whether a bubble is injected into ID/EX, and whether IF/ID is flushed on a taken branch/jump. It covers hazards that operand forwarding cannot hide: load-use, branch-in-ID operand dependencies, and HI/LO occupancy of the multi-cycle multiply/divide unit, which it sequences with an internal FSM and countdown. It sits beside the forwarding unit in ID and drives the PC and pipeline-register enables.

## Interface
- MUL_LAT, 4: multiply latency in cycles (≥2)
- DIV_LAT, 32: divide latency in cycles (≥2, ≥MUL_LAT)
- CNT_W, 6: countdown width; must hold DIV_LAT-1
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- rs_ID, rt_ID  in  5  source registers of the ID instruction
- useRs_ID, useRt_ID  in  1  ID instruction actually reads rs / rt
- branch_ID  in  1  ID instruction is a branch comparing operands in ID
- branchTaken_ID  in  1  ID branch/jump resolved taken
- writeRegAddress_EX, writeRegAddress_MEM  in  5  destinations in EX / MEM
- regWrite_EX_Signal, regWrite_MEM_Signal  in  1  EX / MEM instruction writes the register file
- memRead_EX_Signal, memRead_MEM_Signal  in  1  EX / MEM instruction is a load
- mdStart_ID  in  1  ID instruction is mult/multu/div/divu
- mdIsDiv_ID  in  1  with mdStart_ID: 1 = divide, 0 = multiply
- hiloRead_ID  in  1  ID instruction is mfhi/mflo
- pcWrite  out  1  PC enable
- ifidWrite  out  1  IF/ID enable
- ifidFlush  out  1  clear IF/ID to NOP
- idexFlush  out  1  load bubble into ID/EX
- mdBusy  out  1  multiply/divide unit occupied
- mdDone  out  1  one-cycle pulse: HI/LO valid
- stallCycles  out  32  count of stalled cycles

## Operation
- Register $0 never creates a hazard; all comparisons qualified by nonzero address and the relevant use/write flag.
- loadUse: memRead_EX and regWrite_EX, writeRegAddress_EX matches a used rs_ID/rt_ID.
- branchHaz: branch_ID and a used source matches (a) writeRegAddress_EX with regWrite_EX, or (b) writeRegAddress_MEM with memRead_MEM and regWrite_MEM. A load in EX feeding a branch therefore stalls 2 cycles.
- mdHaz: mdBusy and (hiloRead_ID or mdStart_ID).
- stall = loadUse | branchHaz | mdHaz.
- stall=1: pcWrite=0, ifidWrite=0, idexFlush=1, ifidFlush=0 (branch not resolved while stalled).
- stall=0: pcWrite=1, ifidWrite=1, idexFlush=0, ifidFlush=branchTaken_ID.
- FSM states IDLE, MUL_RUN, DIV_RUN, encoded 2-bit.
  - IDLE: if mdStart_ID and !stall, go MUL_RUN (cnt←MUL_LAT-1) or DIV_RUN (cnt←DIV_LAT-1) per mdIsDiv_ID.
  - MUL_RUN/DIV_RUN: cnt decrements each cycle; at cnt==1 go IDLE and mdDone=1 on the following cycle.
- mdBusy = state≠IDLE. mdDone registered, high exactly one cycle, at the first cycle in IDLE after a run.
- A start issued while busy is stalled until IDLE, then accepted that cycle (back-to-back: one IDLE cycle with mdDone=1 and acceptance together).
- stallCycles increments when stall=1; wraps 0xFFFFFFFF→0.

## Timing
- Reset (rst_n=0, asynchronous): state IDLE, cnt 0, mdDone 0, stallCycles 0; combinational outputs follow reset state (mdBusy=0, pcWrite/ifidWrite=1 unless input hazard).
- Reset mid-run abandons the operation, no mdDone.
- Hazard outputs combinational from inputs and state; same-cycle.
- Multiply: start accepted at edge N → mdBusy high cycles N+1..N+MUL_LAT-1, mdDone at N+MUL_LAT. Divide identical with DIV_LAT.
- hiloRead_ID proceeds in the mdDone cycle.

## Structure
- Shared pipeline package: FSM state typedef, register-index width (5), REG_ZERO constant.
- One sub-module natural: md_sequencer (FSM, countdown, mdBusy/mdDone). Hazard compare and counter stay in top.

## Test plan
- lw $2 in EX (memRead_EX=1, rd=2), add rs=2 in ID → one cycle pcWrite=0, ifidWrite=0, idexFlush=1; stallCycles 0→1.
- lw $3 in EX, beq rs=3 in ID → stall two cycles (EX then MEM match); third cycle branchTaken_ID=1 gives ifidFlush=1.
- Dependencies on $0 (rd=0, regWrite=1, memRead=1) → no stall.
- mult accepted, MUL_LAT=4; mfhi in ID next cycle → stalls 3 cycles, mdDone on 4th, mfhi passes then.
- div accepted, rst_n low for 1 cycle at busy cycle 10 → mdBusy=0 immediately, no mdDone, stallCycles=0.
- branchTaken_ID=1 with concurrent loadUse → ifidFlush=0, idexFlush=1; next cycle no hazard → ifidFlush=1.

Source files
------------

// File: rtl/hazard_stall_controller_pkg.sv
// Shared pipeline definitions for the hazard/stall controller: register index
// width, the $0 constant, multiply/divide FSM encoding and a source-match helper.
package hazard_stall_controller_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = '0;

    typedef logic [1:0] md_state_t;

    localparam md_state_t MD_IDLE    = 2'd0;
    localparam md_state_t MD_MUL_RUN = 2'd1;
    localparam md_state_t MD_DIV_RUN = 2'd2;

    // A source depends on a producer only when both sides are live and the register is not $0.
    function automatic logic src_match(
        input logic [REG_W-1:0] src,
        input logic             src_used,
        input logic [REG_W-1:0] dst,
        input logic             dst_written
    );
        return src_used && dst_written && (dst != REG_ZERO) && (src == dst);
    endfunction

endpackage

// File: rtl/hazard_stall_controller_if.sv
// Bundle of ID/EX/MEM hazard inputs and the pipeline-enable outputs exchanged
// between the pipeline (master) and the hazard controller (slave).
interface hazard_stall_controller_if;
    import hazard_stall_controller_pkg::*;

    logic [REG_W-1:0] rs_ID;
    logic [REG_W-1:0] rt_ID;
    logic             useRs_ID;
    logic             useRt_ID;
    logic             branch_ID;
    logic             branchTaken_ID;
    logic [REG_W-1:0] writeRegAddress_EX;
    logic [REG_W-1:0] writeRegAddress_MEM;
    logic             regWrite_EX_Signal;
    logic             regWrite_MEM_Signal;
    logic             memRead_EX_Signal;
    logic             memRead_MEM_Signal;
    logic             mdStart_ID;
    logic             mdIsDiv_ID;
    logic             hiloRead_ID;
    logic             pcWrite;
    logic             ifidWrite;
    logic             ifidFlush;
    logic             idexFlush;
    logic             mdBusy;
    logic             mdDone;
    logic [31:0]      stallCycles;

    modport master (
        output rs_ID, rt_ID, useRs_ID, useRt_ID, branch_ID, branchTaken_ID,
               writeRegAddress_EX, writeRegAddress_MEM,
               regWrite_EX_Signal, regWrite_MEM_Signal,
               memRead_EX_Signal, memRead_MEM_Signal,
               mdStart_ID, mdIsDiv_ID, hiloRead_ID,
        input  pcWrite, ifidWrite, ifidFlush, idexFlush, mdBusy, mdDone, stallCycles
    );

    modport slave (
        input  rs_ID, rt_ID, useRs_ID, useRt_ID, branch_ID, branchTaken_ID,
               writeRegAddress_EX, writeRegAddress_MEM,
               regWrite_EX_Signal, regWrite_MEM_Signal,
               memRead_EX_Signal, memRead_MEM_Signal,
               mdStart_ID, mdIsDiv_ID, hiloRead_ID,
        output pcWrite, ifidWrite, ifidFlush, idexFlush, mdBusy, mdDone, stallCycles
    );

endinterface

// File: rtl/hazard_stall_controller_md_sequencer.sv
// Tracks HI/LO occupancy of the multi-cycle multiply/divide unit: a small FSM
// with a countdown, producing busy and a one-cycle done pulse.
module md_sequencer
    import hazard_stall_controller_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic is_div,
    output logic busy,
    output logic done
);

    md_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic             done_q;

    // The last run cycle (cnt==1) hands back to IDLE so that done lands on the first idle cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= MD_IDLE;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        state <= is_div ? MD_DIV_RUN : MD_MUL_RUN;
                        cnt   <= is_div ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
                    end
                end
                MD_MUL_RUN, MD_DIV_RUN: begin
                    if (cnt == CNT_W'(1)) begin
                        state  <= MD_IDLE;
                        cnt    <= '0;
                        done_q <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= MD_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign busy = (state != MD_IDLE);
    assign done = done_q;

endmodule

// File: rtl/hazard_stall_controller.sv
// ID-stage hazard controller: detects load-use, branch operand and HI/LO hazards,
// drives PC / IF/ID / ID/EX control and counts stalled cycles.
module hazard_stall_controller
    import hazard_stall_controller_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    hazard_stall_controller_if.slave  bus
);

    logic        load_use;
    logic        branch_haz;
    logic        md_haz;
    logic        stall;
    logic        md_busy;
    logic        md_done;
    logic        md_start;
    logic        ex_rs;
    logic        ex_rt;
    logic        mem_load_rs;
    logic        mem_load_rt;
    logic [31:0] stall_count;

    assign ex_rs       = src_match(bus.rs_ID, bus.useRs_ID, bus.writeRegAddress_EX, bus.regWrite_EX_Signal);
    assign ex_rt       = src_match(bus.rt_ID, bus.useRt_ID, bus.writeRegAddress_EX, bus.regWrite_EX_Signal);
    assign mem_load_rs = src_match(bus.rs_ID, bus.useRs_ID, bus.writeRegAddress_MEM,
                                   bus.regWrite_MEM_Signal & bus.memRead_MEM_Signal);
    assign mem_load_rt = src_match(bus.rt_ID, bus.useRt_ID, bus.writeRegAddress_MEM,
                                   bus.regWrite_MEM_Signal & bus.memRead_MEM_Signal);

    // Branches compare in ID, so even ALU results in EX and loads in MEM are too late to forward.
    assign load_use   = bus.memRead_EX_Signal & (ex_rs | ex_rt);
    assign branch_haz = bus.branch_ID & (ex_rs | ex_rt | mem_load_rs | mem_load_rt);
    assign md_haz     = md_busy & (bus.hiloRead_ID | bus.mdStart_ID);
    assign stall      = load_use | branch_haz | md_haz;
    assign md_start   = bus.mdStart_ID & ~stall;

    md_sequencer #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (CNT_W)
    ) u_md_sequencer (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_start),
        .is_div (bus.mdIsDiv_ID),
        .busy   (md_busy),
        .done   (md_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stall) begin
            stall_count <= stall_count + 32'd1;
        end
    end

    assign bus.pcWrite     = ~stall;
    assign bus.ifidWrite   = ~stall;
    assign bus.idexFlush   = stall;
    assign bus.ifidFlush   = ~stall & bus.branchTaken_ID;
    assign bus.mdBusy      = md_busy;
    assign bus.mdDone      = md_done;
    assign bus.stallCycles = stall_count;

endmodule
